// File: rtl/rf_write_arbiter.sv
// Two-requester write-port arbiter for the register file: per-requester FIFOs,
// round-robin grant, registered write strobe and a pending-write mask.
// Optional contention counter is enabled by defining RFARB_CONFLICT_CNT_EN.
module rf_write_arbiter #(
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          RegWrite,
  output logic [AW-1:0] WR,
  output logic [DW-1:0] data,
  output logic [31:0]   pend_mask,
  output logic          busy,
  output logic [15:0]   conflict_cnt
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  // Index 0 is requester A, index 1 is requester B.
  entry_t           mem        [2][DEPTH];
  logic [DEPTH-1:0] slot_valid [2];
  logic [PW:0]      wr_ptr     [2];
  logic [PW:0]      rd_ptr     [2];
  entry_t           in_entry   [2];
  entry_t           head       [2];
  entry_t           issue;
  logic [1:0]       in_valid;
  logic [1:0]       ready;
  logic [1:0]       empty;
  logic [1:0]       push;
  logic [1:0]       grant;
  logic             contention;
  logic             last_grant_b;

  assign in_valid    = {b_valid, a_valid};
  assign in_entry[0] = {a_addr, a_data};
  assign in_entry[1] = {b_addr, b_data};

  // NOTE: combinational blocks use blocking '=' and give every output a value
  // before any branch, so no latch can be inferred.
  always_comb begin
    empty = '0;
    ready = '0;
    push  = '0;
    for (int i = 0; i < 2; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      // Full when the wrap bits differ but the slot indices match.
      ready[i] = !((wr_ptr[i][PW] != rd_ptr[i][PW]) &&
                   (wr_ptr[i][PW-1:0] == rd_ptr[i][PW-1:0]));
      push[i]  = in_valid[i] && ready[i];
      head[i]  = mem[i][rd_ptr[i][PW-1:0]];
    end
  end

  assign a_ready = ready[0];
  assign b_ready = ready[1];

  // last_grant_b=1 means B won the previous contention, so A has priority.
  assign contention = !empty[0] && !empty[1];
  assign grant[0]   = !empty[0] && (empty[1] || last_grant_b);
  assign grant[1]   = !empty[1] && (empty[0] || !last_grant_b);
  assign issue      = grant[1] ? head[1] : head[0];

  // NOTE: sequential state uses non-blocking '<=' so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i]     <= '0;
        rd_ptr[i]     <= '0;
        slot_valid[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          wr_ptr[i]                         <= wr_ptr[i] + 1'b1;
          slot_valid[i][wr_ptr[i][PW-1:0]]  <= 1'b1;
        end
        if (grant[i]) begin
          rd_ptr[i]                         <= rd_ptr[i] + 1'b1;
          slot_valid[i][rd_ptr[i][PW-1:0]]  <= 1'b0;
        end
      end
    end
  end

  // NOTE: payload storage carries no reset; slot_valid and the pointers alone
  // decide which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) mem[i][wr_ptr[i][PW-1:0]] <= in_entry[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWrite     <= 1'b0;
      WR           <= '0;
      data         <= '0;
      last_grant_b <= 1'b1;
    end else begin
      RegWrite <= 1'b0;
      if (|grant) begin
        // Register 0 is hardwired; its entry drains without a write strobe.
        RegWrite <= (issue.addr != '0);
        WR       <= issue.addr;
        data     <= issue.data;
      end
      if (contention) last_grant_b <= grant[1];
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (slot_valid[i][k]) pend_mask[mem[i][k].addr] = 1'b1;
      end
    end
    if (RegWrite) pend_mask[WR] = 1'b1;
    pend_mask[0] = 1'b0;
  end

  assign busy = (|slot_valid[0]) || (|slot_valid[1]) || RegWrite;

`ifdef RFARB_CONFLICT_CNT_EN
  logic [15:0] conflict_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_q <= '0;
    end else if (contention && (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus random
// traffic, compared against a queue-based reference model every cycle.
module tb_rf_write_arbiter;

  localparam int DEPTH = 2;
  localparam int DW    = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          RegWrite;
  logic [AW-1:0] WR;
  logic [DW-1:0] data;
  logic [31:0]   pend_mask;
  logic          busy;
  logic [15:0]   conflict_cnt;

  rf_write_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .RegWrite(RegWrite), .WR(WR), .data(data),
    .pend_mask(pend_mask), .busy(busy), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } obs_t;

  // Reference model: one queue per requester plus the expected output register.
  wr_t           qa[$], qb[$];
  obs_t          obs[$];
  logic          m_rw;
  logic [AW-1:0] m_wr;
  logic [DW-1:0] m_data;
  bit            m_last_b;
  int            m_conf;
  int            cyc_no = 0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    m_rw     = 1'b0;
    m_wr     = '0;
    m_data   = '0;
    m_last_b = 1'b1;
    m_conf   = 0;
  endtask

  function automatic logic [31:0] exp_pend();
    logic [31:0] m = '0;
    foreach (qa[k]) m[qa[k].addr] = 1'b1;
    foreach (qb[k]) m[qb[k].addr] = 1'b1;
    if (m_rw) m[m_wr] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  function automatic logic [15:0] exp_conf();
`ifdef RFARB_CONFLICT_CNT_EN
    return 16'(m_conf);
`else
    return 16'h0000;
`endif
  endfunction

  // One clock: check state-derived outputs, advance the model, take the edge,
  // then check the registered write port.
  task automatic tick();
    bit  acc_a, acc_b, ga, gb;
    wr_t e;
    check("a_ready", a_ready, qa.size() < DEPTH);
    check("b_ready", b_ready, qb.size() < DEPTH);
    check("pend_mask", pend_mask, exp_pend());
    check("busy", busy, (qa.size() > 0) || (qb.size() > 0) || m_rw);
    check("conflict_cnt", conflict_cnt, exp_conf());
    acc_a = a_valid && (qa.size() < DEPTH);
    acc_b = b_valid && (qb.size() < DEPTH);
    ga = (qa.size() > 0) && ((qb.size() == 0) || m_last_b);
    gb = (qb.size() > 0) && ((qa.size() == 0) || !m_last_b);
    if ((qa.size() > 0) && (qb.size() > 0)) begin
      m_last_b = gb;
      if (m_conf < 65535) m_conf++;
    end
    m_rw = 1'b0;
    if (ga || gb) begin
      e      = ga ? qa.pop_front() : qb.pop_front();
      m_rw   = (e.addr != 0);
      m_wr   = e.addr;
      m_data = e.data;
    end
    if (acc_a) qa.push_back('{addr: a_addr, data: a_data});
    if (acc_b) qb.push_back('{addr: b_addr, data: b_data});
    @(posedge clk);
    #1;
    cyc_no++;
    check("RegWrite", RegWrite, m_rw);
    if (m_rw) begin
      check("WR", WR, m_wr);
      check("data", data, m_data);
    end
    if (RegWrite) obs.push_back('{addr: WR, data: data, cyc: cyc_no});
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int b_seq, a_seq, b_seen, start_idx;
    bit b_acc, a_acc, saw_b_full;

    // Reset values while rst is held low.
    model_reset();
    #2;
    check("rst_RegWrite", RegWrite, 0);
    check("rst_WR", WR, 0);
    check("rst_data", data, 0);
    check("rst_pend_mask", pend_mask, 0);
    check("rst_busy", busy, 0);
    check("rst_conflict", conflict_cnt, 0);
    rst = 1'b1;
    #1;
    check("rst_a_ready", a_ready, 1);
    check("rst_b_ready", b_ready, 1);

    // Reset mid-stream: two A entries, then async reset between edges.
    a_valid = 1'b1; a_addr = 5'd9;  a_data = 32'h0000_0009; tick();
    a_addr = 5'd10; a_data = 32'h0000_000A; tick();
    a_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_RegWrite", RegWrite, 0);
    check("midrst_WR", WR, 0);
    check("midrst_data", data, 0);
    check("midrst_pend_mask", pend_mask, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    obs.delete();
    idle(4);
    check("midrst_no_stale", obs.size(), 0);

    // Single write to r5.
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
    tick();
    a_valid = 1'b0;
    check("single_pend5_after_push", pend_mask[5], 1);
    tick();
    check("single_RegWrite", RegWrite, 1);
    check("single_WR", WR, 5);
    check("single_data", data, 32'hDEAD_BEEF);
    idle(2);

    // Contention: A r1,r2 and B r3,r4 pushed together.
    obs.delete();
    a_valid = 1'b1; b_valid = 1'b1;
    a_addr = 5'd1; a_data = 32'h1111_0001; b_addr = 5'd3; b_data = 32'h3333_0003; tick();
    a_addr = 5'd2; a_data = 32'h2222_0002; b_addr = 5'd4; b_data = 32'h4444_0004; tick();
    idle(5);
    check("cont_count", obs.size(), 4);
    if (obs.size() == 4) begin
      check("cont_order0", obs[0].addr, 1);
      check("cont_order1", obs[1].addr, 3);
      check("cont_order2", obs[2].addr, 2);
      check("cont_order3", obs[3].addr, 4);
      check("cont_back_to_back", obs[3].cyc - obs[0].cyc, 3);
    end
`ifdef RFARB_CONFLICT_CNT_EN
    check("cont_conflict", conflict_cnt, 3);
`else
    check("cont_conflict", conflict_cnt, 0);
`endif

    // Register 0: addr 0 then addr 7 from A.
    obs.delete();
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h0BAD_0000; tick();
    check("r0_pend0", pend_mask[0], 0);
    a_addr = 5'd7; a_data = 32'h0777_0007; tick();
    check("r0_no_pulse", RegWrite, 0);
    check("r0_pend0_b", pend_mask[0], 0);
    idle(3);
    check("r0_one_write", obs.size(), 1);
    if (obs.size() == 1) check("r0_write_r7", obs[0].addr, 7);

    // Backpressure: A streams continuously, B holds its payload until taken.
    obs.delete();
    start_idx = 0;
    a_seq = 0; b_seq = 0; saw_b_full = 1'b0;
    a_valid = 1'b1;
    a_addr = 5'(1 + a_seq % 4); a_data = 32'hA000_0000 | a_seq;
    a_acc = a_ready; tick(); if (a_acc) a_seq++;
    b_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a_addr = 5'(1 + a_seq % 4); a_data = 32'hA000_0000 | a_seq;
      b_addr = 5'(8 + b_seq % 8); b_data = 32'hB000_0000 | b_seq;
      a_acc = a_ready;
      b_acc = b_ready;
      if (!b_ready) saw_b_full = 1'b1;
      tick();
      if (a_acc) a_seq++;
      if (b_acc) b_seq++;
    end
    idle(8);
    check("bp_b_ready_dropped", saw_b_full, 1);
    b_seen = 0;
    foreach (obs[k]) begin
      if (obs[k].data[31:28] == 4'hB) begin
        check("bp_b_seq", obs[k].data, 32'hB000_0000 | b_seen);
        b_seen++;
      end
    end
    check("bp_b_count", b_seen, b_seq);

    // Random traffic, addresses include register 0.
    for (int i = 0; i < 400; i++) begin
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
      a_addr  = 5'($urandom_range(0, 7));
      b_addr  = 5'($urandom_range(0, 7));
      a_data  = $urandom;
      b_data  = $urandom;
      tick();
    end
    idle(6);
    check("rand_drained_busy", busy, 0);

`ifdef RFARB_CONFLICT_CNT_EN
    // Saturation: both FIFOs kept non-empty long enough to pin the counter.
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      a_addr = 5'($urandom_range(1, 31)); a_data = $urandom;
      b_addr = 5'($urandom_range(1, 31)); b_data = $urandom;
      tick();
    end
    check("sat_conflict", conflict_cnt, 16'hFFFF);
    idle(4);
    check("sat_hold", conflict_cnt, 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (RegWrite / WR / data) between two writeback requesters.
  - Requester A: ALU writeback.
  - Requester B: load / multi-cycle unit return.
- Each requester gets a small FIFO behind a valid/ready handshake.
- Grants round-robin and drives a registered write strobe into the register file.
- Exports a per-register pending-write mask that the hazard/stall logic uses to hold dependent reads.

Parameters:
- DEPTH, 2, entries per requester FIFO (power of two, ≥2)
- DW, 32, write data width
- AW, 5, register address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- a_valid  in  1  requester A has a write
- a_ready  out  1  A FIFO can accept (not full)
- a_addr  in  AW  A destination register
- a_data  in  DW  A write data
- b_valid  in  1  requester B has a write
- b_ready  out  1  B FIFO can accept (not full)
- b_addr  in  AW  B destination register
- b_data  in  DW  B write data
- RegWrite  out  1  write strobe to register file, registered
- WR  out  AW  write address to register file, registered
- data  out  DW  write data to register file, registered
- pend_mask  out  32  bit i = 1 while a write to register i is queued or issuing
- busy  out  1  any FIFO non-empty or RegWrite high
- conflict_cnt  out  16  contention statistic (see Optional Feature)

Behaviour:
- Reset (rst=0, async): both FIFOs empty; RegWrite=0, WR=0, data=0; pend_mask=0; busy=0; last_grant=B (so A wins first contention); a_ready=b_ready=1 once rst deasserts.
- Accept: entry pushed at the clock edge when x_valid && x_ready.
  - x_ready = FIFO not full; it is combinational on FIFO state only, never on x_valid.
  - A full FIFO pushes nothing; the requester must hold its payload until accepted.
- Simultaneous push and pop on the same FIFO in one cycle are legal.
  - Count unchanged.
  - When full, x_ready stays 0 that cycle; no push-through.
- Arbitration, each cycle, on FIFO heads:
  - Only one non-empty: grant it.
  - Both non-empty: grant the side not in last_grant; last_grant updates to the granted side.
  - Neither non-empty: no grant; last_grant holds.
- Issue: the granted head pops at the edge and loads the output register.
  - RegWrite=1 for exactly one cycle per popped entry, with WR/data from the entry.
  - RegWrite=0 in cycles with no grant; WR/data hold their last values.
- Latency: a push at edge N gives RegWrite high after edge N+1 at the earliest.
- Throughput: one write per cycle sustained.
- Register 0: an entry with addr=0 is accepted and popped normally but issues RegWrite=0. It never sets pend_mask bit 0, and pend_mask[0] is always 0.
- pend_mask[i] (i≠0) = OR over all valid FIFO entries and the output register (while RegWrite=1) whose address equals i. It is combinational from state; no clock delay.
- Ordering:
  - FIFO order within one requester is preserved.
  - Between requesters, order is arbitration order only. The issuing pipeline must not have both requesters target the same register concurrently; pend_mask exists to enforce this.
- Pointer wrap: read/write pointers wrap modulo DEPTH. An extra MSB distinguishes full from empty.

Optional Feature:
- Macro: RFARB_CONFLICT_CNT_EN.
- Defined:
  - conflict_cnt increments each cycle both FIFOs are non-empty at arbitration.
  - It saturates at 16'hFFFF and is cleared to 0 by rst.
- Undefined: conflict_cnt tied to 16'h0000; no counter flops.

Test Plan:
- Reset mid-stream: fill A with 2 entries, assert rst=0 between edges -> RegWrite/WR/data/pend_mask go 0 immediately; after release, no stale writes issue.
- Single write: A pushes addr=5, data=0xDEADBEEF at edge N -> RegWrite=1, WR=5, data=0xDEADBEEF for exactly the cycle after edge N+1; pend_mask[5]=1 from edge N until that cycle ends.
- Contention: both FIFOs hold 2 entries (A: r1,r2; B: r3,r4) -> issue order r1,r3,r2,r4 with RegWrite high 4 consecutive cycles; conflict_cnt=3 with macro defined, 0 without.
- Backpressure: hold b_valid=1 with DEPTH=2, no pops possible (A streaming continuously, A first) -> b_ready=0 after 2 accepts; the third B payload is taken only after a B pop; no entry lost or duplicated.
- Register 0: A pushes addr=0 then addr=7 -> no RegWrite pulse for r0; r7 write issues one cycle later; pend_mask[0] stays 0 throughout.
- Saturation (macro on): keep both FIFOs non-empty for 70000 cycles -> conflict_cnt holds at 0xFFFF.
